// File: rtl/sha3_pad64_pkg.sv
// Shared SHA3 constants: mode codes, rate table, domain bytes and the padder FSM encoding.
`ifndef SHA3_B
`define SHA3_B 1600
`endif

package sha3_pad64_pkg;

  localparam int LANE_W = `SHA3_B / 25;

  localparam logic [2:0] MODE_SHAKE128 = 3'd0;
  localparam logic [2:0] MODE_SHAKE256 = 3'd1;
  localparam logic [2:0] MODE_SHA3_512 = 3'd2;
  localparam logic [2:0] MODE_SHA3_384 = 3'd3;
  localparam logic [2:0] MODE_SHA3_256 = 3'd4;
  localparam logic [2:0] MODE_SHA3_224 = 3'd5;

  localparam logic [7:0] DOM_SHAKE = 8'h1F;
  localparam logic [7:0] DOM_SHA3  = 8'h06;
  localparam logic [7:0] PAD_END   = 8'h80;

  typedef enum logic [2:0] {S_IDLE, S_ABSORB, S_PAD, S_BLOCK, S_FLUSH} state_e;

  // Rate in 64-bit lanes; unused mode codes fall back to SHA3-256.
  function automatic logic [4:0] rate_words(input logic [2:0] mode);
    logic [4:0] r;
    case (mode)
      MODE_SHAKE128: r = 5'd21;
      MODE_SHAKE256: r = 5'd17;
      MODE_SHA3_512: r = 5'd9;
      MODE_SHA3_384: r = 5'd13;
      MODE_SHA3_256: r = 5'd17;
      MODE_SHA3_224: r = 5'd18;
      default:       r = 5'd17;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] dom_byte(input logic [2:0] mode);
    return (mode == MODE_SHAKE128 || mode == MODE_SHAKE256) ? DOM_SHAKE : DOM_SHA3;
  endfunction

endpackage

// File: rtl/sha3_pad_word.sv
// Per-byte masking of a lane word plus insertion of the domain byte and the final 0x80 pad bit.
module sha3_pad_word
  import sha3_pad64_pkg::*;
(
  input  logic [LANE_W-1:0] word,
  input  logic [3:0]        nbytes,
  input  logic [7:0]        dbyte,
  input  logic              is_last_pos,
  input  logic              is_pad_start,
  output logic [LANE_W-1:0] padded
);

  for (genvar i = 0; i < 8; i++) begin : g_byte
    localparam logic [3:0] IDX = 4'(i);
    logic [7:0] b;
    always_comb begin
      b = (IDX < nbytes) ? word[8*i +: 8] : 8'h00;
      // nbytes==8 never matches an index, so full words get no domain byte
      if (is_pad_start && IDX == nbytes) b = b | dbyte;
      if (is_last_pos && i == 7)         b = b | PAD_END;
    end
    assign padded[8*i +: 8] = b;
  end

endmodule

// File: rtl/sha3_pad64.sv
// SHA3/SHAKE message padder: streams 64-bit lanes into the absorb shift register and hands
// off full rate blocks to the permutation.
module sha3_pad64
  import sha3_pad64_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic [2:0]        mode_sel_i,
  input  logic              msg_valid,
  input  logic [LANE_W-1:0] msg_data,
  input  logic              msg_last,
  input  logic [3:0]        msg_nbytes,
  output logic              msg_ready,
  output logic [0:LANE_W-1] din64,
  output logic              hash_ready,
  output logic              flag,
  output logic              block_valid,
  output logic              block_last,
  input  logic              block_ack
);

  state_e            state, state_n;
  logic [4:0]        wcnt, wcnt_n, wcnt_inc, rate;
  logic [2:0]        mode_q, mode_n, mode_cur;
  logic [7:0]        dom;
  logic              blk_last_q, blk_last_n, pend_d_q, pend_d_n, rdy_en;
  logic              accept, shift, at_end, last_pos;
  logic [3:0]        nb, pw_nb;
  logic [LANE_W-1:0] pw_word, pw_out;
  logic              pw_last_pos, pw_pad_start;

  // Mode is live from the input only while idle; afterwards the latched copy rules.
  assign mode_cur  = (state == S_IDLE) ? mode_sel_i : mode_q;
  assign rate      = rate_words(mode_cur);
  assign dom       = dom_byte(mode_cur);
  assign msg_ready = rdy_en && (state == S_IDLE || state == S_ABSORB);
  assign accept    = msg_valid && msg_ready;
  assign shift     = accept || (state == S_PAD);
  assign wcnt_inc  = wcnt + 5'd1;
  assign at_end    = (wcnt_inc == rate);
  assign last_pos  = (wcnt == rate - 5'd1);
  assign nb        = !msg_last ? 4'd8 : ((msg_nbytes > 4'd8) ? 4'd8 : msg_nbytes);

  always_comb begin
    if (state == S_PAD) begin
      pw_word      = '0;
      pw_nb        = 4'd0;
      pw_pad_start = pend_d_q;
      pw_last_pos  = last_pos;
    end else begin
      pw_word      = msg_data;
      pw_nb        = nb;
      pw_pad_start = msg_last;
      pw_last_pos  = last_pos && msg_last && (nb != 4'd8);
    end
  end

  sha3_pad_word u_pad_word (
    .word        (pw_word),
    .nbytes      (pw_nb),
    .dbyte       (dom),
    .is_last_pos (pw_last_pos),
    .is_pad_start(pw_pad_start),
    .padded      (pw_out)
  );

  always_comb begin
    state_n     = state;
    wcnt_n      = wcnt;
    mode_n      = mode_q;
    blk_last_n  = blk_last_q;
    pend_d_n    = pend_d_q;
    hash_ready  = !shift;
    din64       = shift ? pw_out : '0;
    flag        = 1'b0;
    block_valid = 1'b0;
    block_last  = 1'b0;
    case (state)
      S_IDLE, S_ABSORB: begin
        if (accept) begin
          if (state == S_IDLE) mode_n = mode_sel_i;
          wcnt_n = wcnt_inc;
          if (msg_last) begin
            // A full last word leaves the domain byte for the next emitted word.
            pend_d_n   = (nb == 4'd8);
            blk_last_n = (nb != 4'd8);
            state_n    = at_end ? S_BLOCK : S_PAD;
          end else begin
            blk_last_n = 1'b0;
            state_n    = at_end ? S_BLOCK : S_ABSORB;
          end
        end
      end
      S_PAD: begin
        wcnt_n   = wcnt_inc;
        pend_d_n = 1'b0;
        if (at_end) begin
          blk_last_n = 1'b1;
          state_n    = S_BLOCK;
        end
      end
      S_BLOCK: begin
        block_valid = 1'b1;
        block_last  = blk_last_q;
        if (block_ack) begin
          wcnt_n  = '0;
          state_n = blk_last_q ? S_FLUSH : (pend_d_q ? S_PAD : S_ABSORB);
        end
      end
      S_FLUSH: begin
        flag    = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      wcnt       <= '0;
      mode_q     <= MODE_SHA3_256;
      blk_last_q <= 1'b0;
      pend_d_q   <= 1'b0;
      rdy_en     <= 1'b0;
    end else begin
      state      <= state_n;
      wcnt       <= wcnt_n;
      mode_q     <= mode_n;
      blk_last_q <= blk_last_n;
      pend_d_q   <= pend_d_n;
      rdy_en     <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sha3_pad64.sv
// Bench for sha3_pad64: table of messages checked against a byte-level SHA3 padding model.
module tb_sha3_pad64;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  mode_sel_i;
  logic        msg_valid, msg_last;
  logic [63:0] msg_data;
  logic [3:0]  msg_nbytes;
  logic        msg_ready, hash_ready, flag, block_valid, block_last;
  logic [0:63] din64;
  logic        ack_r, stray_ack;

  sha3_pad64 dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .mode_sel_i (mode_sel_i),
    .msg_valid  (msg_valid),
    .msg_data   (msg_data),
    .msg_last   (msg_last),
    .msg_nbytes (msg_nbytes),
    .msg_ready  (msg_ready),
    .din64      (din64),
    .hash_ready (hash_ready),
    .flag       (flag),
    .block_valid(block_valid),
    .block_last (block_last),
    .block_ack  (ack_r | stray_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    int mode; int nfull; int lastnb; int ack_dly;
    int exp_words; int exp_blocks;
  } vec_t;

  vec_t        vecs[12];
  logic [63:0] exp_q[$];
  logic        blast_q[$];
  int          n_cmp = 0, n_err = 0;
  int          flags = 0, shifts = 0, blocks = 0, ack_dly = 0;
  bit          sb_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s: event missing or unexpected", nm);
  endtask

  function automatic int rate_of(input int m);
    case (m)
      0: return 21;
      1: return 17;
      2: return 9;
      3: return 13;
      5: return 18;
      default: return 17;
    endcase
  endfunction

  function automatic logic [7:0] dom_of(input int m);
    return (m < 2) ? 8'h1F : 8'h06;
  endfunction

  // Scoreboard: every shifted lane is popped and compared; idle cycles must show zero.
  always @(negedge clk) begin
    if (flag) begin
      flags++;
      chk("flag_hash_ready", {63'd0, hash_ready}, 64'd1);
    end
    if (!hash_ready) begin
      shifts++;
      if (sb_en) begin
        if (exp_q.size() == 0) fail("extra_shift");
        else chk("din64", din64, exp_q.pop_front());
      end
    end else begin
      chk("din64_hold_zero", din64, 64'd0);
    end
  end

  // Permutation stand-in: checks block_last, optionally stalls, then acks once.
  initial begin
    ack_r = 1'b0;
    forever begin
      @(negedge clk);
      if (block_valid) begin
        blocks++;
        if (blast_q.size() == 0) fail("extra_block");
        else chk("block_last", {63'd0, block_last}, {63'd0, blast_q.pop_front()});
        for (int i = 0; i < ack_dly; i++) begin
          @(negedge clk);
          chk("stall_valid", {63'd0, block_valid}, 64'd1);
          chk("stall_hash_ready", {63'd0, hash_ready}, 64'd1);
          chk("stall_msg_ready", {63'd0, msg_ready}, 64'd0);
        end
        @(posedge clk); #1 ack_r = 1'b1;
        @(posedge clk); #1 ack_r = 1'b0;
      end
    end
  end

  task automatic put_word(input logic [63:0] d, input bit last, input int nb);
    int t = 0;
    msg_valid = 1'b1; msg_data = d; msg_last = last; msg_nbytes = 4'(nb);
    @(negedge clk);
    while (!msg_ready && t < 300) begin @(negedge clk); t++; end
    if (!msg_ready) fail("accept_timeout");
    @(posedge clk); #1;
  endtask

  task automatic wait_flag(input int f0);
    int t = 0;
    while (flags == f0 && t < 400) begin @(negedge clk); t++; end
    if (flags == f0) fail("flag_timeout");
    @(posedge clk); #1;
  endtask

  task automatic send_msg(input vec_t v);
    logic [63:0] w[$];
    logic [7:0]  pb[$];
    logic [63:0] lane;
    int rb, tot, f0, s0, b0;
    for (int k = 0; k <= v.nfull; k++) w.push_back({$urandom, $urandom});
    for (int k = 0; k < v.nfull; k++)
      for (int b = 0; b < 8; b++) pb.push_back(w[k][8*b +: 8]);
    for (int b = 0; b < v.lastnb; b++) pb.push_back(w[v.nfull][8*b +: 8]);
    rb  = rate_of(v.mode) * 8;
    tot = ((pb.size() + rb) / rb) * rb;
    pb.push_back(dom_of(v.mode));
    while (pb.size() < tot) pb.push_back(8'h00);
    pb[tot-1] = pb[tot-1] | 8'h80;
    for (int i = 0; i < tot / 8; i++) begin
      for (int b = 0; b < 8; b++) lane[8*b +: 8] = pb[8*i + b];
      exp_q.push_back(lane);
    end
    for (int i = 0; i < tot / rb; i++) blast_q.push_back(i == tot / rb - 1);
    f0 = flags; s0 = shifts; b0 = blocks;
    ack_dly = v.ack_dly;
    mode_sel_i = 3'(v.mode);
    for (int k = 0; k <= v.nfull; k++) begin
      put_word(w[k], k == v.nfull, (k == v.nfull) ? v.lastnb : 8);
      if (k == 0) mode_sel_i = 3'($urandom);  // must not disturb the running message
    end
    msg_valid = 1'b0; msg_last = 1'b0;
    wait_flag(f0);
    chk("words_left", 64'(exp_q.size()), 64'd0);
    chk("blocks_left", 64'(blast_q.size()), 64'd0);
    chk("flag_count", 64'(flags - f0), 64'd1);
    chk("shift_count", 64'(shifts - s0), 64'(v.exp_words));
    chk("block_count", 64'(blocks - b0), 64'(v.exp_blocks));
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_hash_ready"}, {63'd0, hash_ready}, 64'd1);
    chk({nm, "_flag"}, {63'd0, flag}, 64'd0);
    chk({nm, "_block_valid"}, {63'd0, block_valid}, 64'd0);
    chk({nm, "_block_last"}, {63'd0, block_last}, 64'd0);
    chk({nm, "_din64"}, din64, 64'd0);
    chk({nm, "_msg_ready"}, {63'd0, msg_ready}, 64'd0);
  endtask

  initial begin
    #400000;
    fail("global_timeout");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "simulation timeout");
  end

  initial begin
    int f0;
    //            mode nfull lastnb ack words blocks
    vecs[0]  = '{4,  0,  0,  0, 17, 1};   // SHA3-256 empty message
    vecs[1]  = '{0,  3,  3,  0, 21, 1};   // SHAKE128 3 bytes tail
    vecs[2]  = '{2,  8,  8,  0, 18, 2};   // SHA3-512 full last word closes block
    vecs[3]  = '{5, 17,  7,  0, 18, 1};   // SHA3-224 D|0x80 in last lane
    vecs[4]  = '{4,  2,  2, 10, 17, 1};   // long block stall
    vecs[5]  = '{1,  5,  8,  2, 17, 1};
    vecs[6]  = '{3, 12,  1,  3, 13, 1};
    vecs[7]  = '{6,  0,  8,  1, 17, 1};   // reserved mode code
    vecs[8]  = '{7, 20,  4,  0, 34, 2};
    vecs[9]  = '{0, 20,  0,  0, 21, 1};   // D and 0x80 share the last lane
    vecs[10] = '{4, 16,  5,  0, 17, 1};
    vecs[11] = '{2, 17,  8,  1, 27, 3};

    reset_n = 1'b1; msg_valid = 1'b0; msg_data = '0; msg_last = 1'b0;
    msg_nbytes = '0; mode_sel_i = 3'd4; stray_ack = 1'b0;
    #1 reset_n = 1'b0;
    #1 chk_reset_outputs("reset");
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_reset", {63'd0, msg_ready}, 64'd1);
    sb_en = 1'b1;

    for (int i = 0; i < 12; i++) send_msg(vecs[i]);

    // Stray ack while idle must be ignored.
    f0 = flags;
    stray_ack = 1'b1;
    repeat (3) @(posedge clk);
    #1 stray_ack = 1'b0;
    chk("stray_ack_flag", 64'(flags - f0), 64'd0);
    chk("stray_ack_ready", {63'd0, msg_ready}, 64'd1);

    // Reset in the middle of padding at wcnt=5.
    sb_en = 1'b0;
    f0 = flags;
    mode_sel_i = 3'd4;
    put_word(64'h0000_0000_0000_2211, 1'b1, 2);
    msg_valid = 1'b0; msg_last = 1'b0;
    repeat (4) @(posedge clk);
    #1 chk("pad_shifting", {63'd0, hash_ready}, 64'd0);
    reset_n = 1'b0;
    #1 chk_reset_outputs("mid_pad_reset");
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_mid_reset", {63'd0, msg_ready}, 64'd1);
    chk("no_flag_after_abort", 64'(flags - f0), 64'd0);
    sb_en = 1'b1;
    send_msg(vecs[1]);
    send_msg(vecs[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
